// File: rtl/msrv32_imm_arbiter.sv
// Two-requester arbiter sharing one immediate generator; one request in flight at a time.
// Optional round-robin arbitration under MSRV32_IMM_ARB_RR_EN (default: fixed priority, req0 wins).
module msrv32_imm_arbiter (
  input  logic                       ms_riscv32_mp_clk_in,
  input  logic                       ms_riscv32_mp_rst_n_in,
  input  logic                       req0_valid_in,
  input  logic [31:0]                req0_instr_in,
  input  logic [2:0]                 req0_imm_type_in,
  output logic                       req0_ready_out,
  input  logic                       req1_valid_in,
  input  logic [31:0]                req1_instr_in,
  input  logic [2:0]                 req1_imm_type_in,
  output logic                       req1_ready_out,
  output logic [31:0]                gen_instr_out,
  output logic [2:0]                 gen_imm_type_out,
  input  logic [31:0]                gen_imm_in,
  output logic                       resp_valid_out,
  output logic                       resp_id_out,
  output logic [31:0]                resp_imm_out,
  input  logic                       resp_ready_in,
  output logic                       busy_out
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned TW   = 3;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t          state_q, state_d;
  logic            win_c;
  logic            grant_en_c;
  logic            id_q;

`ifdef MSRV32_IMM_ARB_RR_EN
  logic            last_q;

  // On a tie the requester not granted last wins.
  always_comb begin
    win_c = req1_valid_in;
    if (req0_valid_in && req1_valid_in) win_c = ~last_q;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) last_q <= 1'b1;
    else if (grant_en_c)         last_q <= win_c;
  end
`else
  always_comb win_c = req1_valid_in & ~req0_valid_in;
`endif

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) state_q <= IDLE;
    else                         state_q <= state_d;
  end

  // Next state and combinational accept handshake; readies are masked during reset.
  always_comb begin
    state_d        = state_q;
    grant_en_c     = 1'b0;
    req0_ready_out = 1'b0;
    req1_ready_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (ms_riscv32_mp_rst_n_in && (req0_valid_in || req1_valid_in)) begin
          grant_en_c     = 1'b1;
          req0_ready_out = ~win_c;
          req1_ready_out = win_c;
          state_d        = EVAL;
        end
      end
      EVAL:    state_d = RESP;
      RESP:    if (resp_ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_out = (state_q != IDLE);

  // Generator operands change only on a grant; response captured one cycle later.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      gen_instr_out    <= '0;
      gen_imm_type_out <= '0;
      id_q             <= 1'b0;
      resp_valid_out   <= 1'b0;
      resp_id_out      <= 1'b0;
      resp_imm_out     <= '0;
    end else begin
      if (grant_en_c) begin
        gen_instr_out    <= win_c ? XLEN'(req1_instr_in) : XLEN'(req0_instr_in);
        gen_imm_type_out <= win_c ? TW'(req1_imm_type_in) : TW'(req0_imm_type_in);
        id_q             <= win_c;
      end
      if (state_q == EVAL) begin
        resp_imm_out   <= gen_imm_in;
        resp_id_out    <= id_q;
        resp_valid_out <= 1'b1;
      end else if (state_q == RESP && resp_ready_in) begin
        resp_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_msrv32_imm_arbiter.sv
// Bench for msrv32_imm_arbiter: per-cycle model compare plus directed literal checks.
// Honours MSRV32_IMM_ARB_RR_EN to pick the expected arbitration policy.
module tb_msrv32_imm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_instr = '0, req1_instr = '0;
  logic [2:0]  req0_type = '0, req1_type = '0;
  logic        req0_ready, req1_ready;
  logic [31:0] gen_instr;
  logic [2:0]  gen_type;
  logic [31:0] gen_imm;
  logic        resp_valid, resp_id;
  logic [31:0] resp_imm;
  logic        resp_ready = 1'b1;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Stand-in immediate generator: any deterministic function of instr and type.
  function automatic logic [31:0] gen_fn(logic [31:0] i, logic [2:0] t);
    return i ^ (32'h01010101 * 32'(t));
  endfunction

  assign gen_imm = gen_fn(gen_instr, gen_type);

  msrv32_imm_arbiter dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .req0_valid_in          (req0_valid),
    .req0_instr_in          (req0_instr),
    .req0_imm_type_in       (req0_type),
    .req0_ready_out         (req0_ready),
    .req1_valid_in          (req1_valid),
    .req1_instr_in          (req1_instr),
    .req1_imm_type_in       (req1_type),
    .req1_ready_out         (req1_ready),
    .gen_instr_out          (gen_instr),
    .gen_imm_type_out       (gen_type),
    .gen_imm_in             (gen_imm),
    .resp_valid_out         (resp_valid),
    .resp_id_out            (resp_id),
    .resp_imm_out           (resp_imm),
    .resp_ready_in          (resp_ready),
    .busy_out               (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: outstanding request age (-1 free, 0 generator busy, >=1 response waiting).
  int          m_age = -1;
  logic        m_last = 1'b1;
  logic        m_id = 1'b0;
  logic [31:0] m_gen_instr = '0;
  logic [2:0]  m_gen_type = '0;
  logic        m_resp_valid = 1'b0, m_resp_id = 1'b0;
  logic [31:0] m_resp_imm = '0;

  int          grant_log[$];
  logic [32:0] resp_log[$];

  always @(negedge clk) begin
    logic w, any, e_r0, e_r1;
    if (!rst_n) begin
      m_age = -1; m_last = 1'b1; m_id = 1'b0; m_gen_instr = '0; m_gen_type = '0;
      m_resp_valid = 1'b0; m_resp_id = 1'b0; m_resp_imm = '0;
    end
    any = req0_valid | req1_valid;
`ifdef MSRV32_IMM_ARB_RR_EN
    w = (req0_valid && req1_valid) ? ~m_last : req1_valid;
`else
    w = req1_valid && !req0_valid;
`endif
    e_r0 = rst_n && (m_age < 0) && any && !w;
    e_r1 = rst_n && (m_age < 0) && any && w;
    chk("m_req0_ready", req0_ready, e_r0);
    chk("m_req1_ready", req1_ready, e_r1);
    chk("m_busy", busy, m_age >= 0);
    chk("m_gen_instr", gen_instr, m_gen_instr);
    chk("m_gen_type", gen_type, m_gen_type);
    chk("m_resp_valid", resp_valid, m_resp_valid);
    chk("m_resp_id", resp_id, m_resp_id);
    chk("m_resp_imm", resp_imm, m_resp_imm);
    if (req0_ready) grant_log.push_back(0);
    if (req1_ready) grant_log.push_back(1);
    if (resp_valid && resp_ready) resp_log.push_back({resp_id, resp_imm});
    if (rst_n) begin
      if (m_age < 0) begin
        if (any) begin
          m_gen_instr = w ? req1_instr : req0_instr;
          m_gen_type  = w ? req1_type : req0_type;
          m_id = w; m_last = w; m_age = 0;
        end
      end else if (m_age == 0) begin
        m_resp_valid = 1'b1; m_resp_id = m_id;
        m_resp_imm = gen_fn(m_gen_instr, m_gen_type);
        m_age = 1;
      end else if (resp_ready) begin
        m_resp_valid = 1'b0; m_age = -1;
      end else begin
        m_age++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] exp_g[4];
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_gen_instr", gen_instr, 0);
    rst_n = 1'b1;

    // Single request from req0
    req0_valid = 1'b1; req0_instr = 32'h81234567; req0_type = 3'b001;
    #1 chk("single_ready0", req0_ready, 1);
    chk("single_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    chk("single_gen_instr", gen_instr, 32'h81234567);
    chk("single_gen_type", gen_type, 3'b001);
    chk("single_ready0_pulse", req0_ready, 0);
    chk("single_eval_valid", resp_valid, 0);
    tick();
    chk("single_resp_valid", resp_valid, 1);
    chk("single_resp_id", resp_id, 0);
    chk("single_resp_imm", resp_imm, 32'h80224466);
    tick();
    chk("single_done", resp_valid, 0);

    // Simultaneous requests, held for four issue slots
    do_reset();
    base = grant_log.size();
    req0_valid = 1'b1; req0_instr = 32'h11111093; req0_type = 3'b000;
    req1_valid = 1'b1; req1_instr = 32'h22222013; req1_type = 3'b010;
    repeat (12) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) tick();
`ifdef MSRV32_IMM_ARB_RR_EN
    exp_g = '{32'd0, 32'd1, 32'd0, 32'd1};
`else
    exp_g = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
    chk("tie_grant_count", grant_log.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < grant_log.size()) chk($sformatf("tie_grant%0d", i), grant_log[base + i], exp_g[i]);

    // Backpressure in RESP with a competing request pending
    resp_ready = 1'b0;
    req1_valid = 1'b1; req1_instr = 32'h00000003; req1_type = 3'b101;
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", resp_valid, 1);
      chk("bp_id", resp_id, 1);
      chk("bp_imm", resp_imm, 32'h05050506);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      chk("bp_busy", busy, 1);
      tick();
    end
    req0_valid = 1'b0; resp_ready = 1'b1;
    tick();
    chk("bp_release", resp_valid, 0);

    // Reset while the request is in EVAL
    req0_valid = 1'b1; req0_instr = 32'hFF23AB35; req0_type = 3'b010;
    tick();
    req0_valid = 1'b0;
    chk("mid_gen_instr_pre", gen_instr, 32'hFF23AB35);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_gen_instr", gen_instr, 0);
    chk("mid_gen_type", gen_type, 0);
    chk("mid_busy", busy, 0);
    chk("mid_resp_valid", resp_valid, 0);
    chk("mid_resp_imm", resp_imm, 0);
    tick();
    rst_n = 1'b1;
    base = resp_log.size();
    repeat (5) tick();
    chk("mid_no_resp", resp_log.size() - base, 0);

    // Type passthrough on req1, all eight codes
    base = resp_log.size();
    req1_instr = 32'hABCDE13F;
    for (int t = 0; t < 8; t++) begin
      req1_valid = 1'b1; req1_type = 3'(t);
      tick();
      req1_valid = 1'b0;
      chk($sformatf("type_gen%0d", t), gen_type, 32'(t));
      tick(); tick();
    end
    chk("type_resp_count", resp_log.size() - base, 8);
    for (int t = 0; t < 8; t++)
      if (base + t < resp_log.size()) begin
        chk($sformatf("type_resp_id%0d", t), 32'(resp_log[base + t][32]), 1);
        chk($sformatf("type_resp_imm%0d", t), resp_log[base + t][31:0],
            gen_fn(32'hABCDE13F, 3'(t)));
      end
    chk("type_resp_imm0_lit", (base < resp_log.size()) ? resp_log[base][31:0] : 32'h0, 32'hABCDE13F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
